// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC selection across trap, stall, call/return,
// jump and branch sources, with a circular return-address stack.
module pc_unit #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_VEC = '0,
    parameter logic [XLEN-1:0]       INC       = XLEN'(1),
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           branch,
    input  logic                           zero,
    input  logic [XLEN-1:0]                br_offset,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [XLEN-1:0]                jmp_target,
    input  logic                           trap,
    input  logic [XLEN-1:0]                trap_vec,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                pc_inc,
    output logic [XLEN-1:0]                epc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [PW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   top_idx;
    logic            ras_empty;
    logic            ras_full;

    assign pc_inc    = pc_q + INC;
    assign top_idx   = wp_q - PW'(1);
    assign ras_empty = (cnt_q == CW'(0));
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    // Next-PC and RAS update; wp_q is the next free slot, so the top lives at wp_q-1.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        ras_d = ras_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (trap) begin
            pc_d  = trap_vec;
            epc_d = pc_q;
        end else if (!stall) begin
            if (call && ret && !ras_empty) begin
                pc_d           = jmp_target;
                ras_d[top_idx] = pc_inc;
            end else if (ret && !call) begin
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_idx];
                    wp_d  = top_idx;
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (call) begin
                // Full stack: pointer wraps onto the oldest entry, count saturates.
                pc_d        = jmp_target;
                ras_d[wp_q] = pc_inc;
                wp_d        = wp_q + PW'(1);
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (jump) begin
                pc_d = jmp_target;
            end else if (branch && zero) begin
                pc_d = pc_q + br_offset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit: each row is one cycle of stimulus and the state
// expected after the following rising edge, queued and checked one cycle later.
module tb_pc_unit;

    localparam logic [6:0] TRP = 7'b1000000;
    localparam logic [6:0] STL = 7'b0100000;
    localparam logic [6:0] RET = 7'b0010000;
    localparam logic [6:0] CAL = 7'b0001000;
    localparam logic [6:0] JMP = 7'b0000100;
    localparam logic [6:0] BR  = 7'b0000010;
    localparam logic [6:0] ZR  = 7'b0000001;
    localparam logic [6:0] NON = 7'b0000000;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] off;
        logic [31:0] tgt;
        logic [31:0] tvec;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch, zero, jump, call, ret, trap;
    logic [31:0] br_offset, jmp_target, trap_vec;
    logic [31:0] pc, pc_inc, epc;
    logic [2:0]  ras_count;
    logic        ras_ovf, ras_unf;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h100), .INC(32'd1), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
        .br_offset(br_offset), .jump(jump), .call(call), .ret(ret),
        .jmp_target(jmp_target), .trap(trap), .trap_vec(trap_vec),
        .pc(pc), .pc_inc(pc_inc), .epc(epc), .ras_count(ras_count),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] off,
                                input logic [31:0] tgt, input logic [31:0] tvec,
                                input logic [31:0] epc_pc, input logic [31:0] e_epc,
                                input logic [2:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.ctl = ctl; v.off = off; v.tgt = tgt; v.tvec = tvec;
        v.pc = epc_pc; v.epc = e_epc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t e);
        chk("pc", idx, pc, e.pc);
        chk("pc_inc", idx, pc_inc, e.pc + 32'd1);
        chk("epc", idx, epc, e.epc);
        chk("ras_count", idx, 32'(ras_count), 32'(e.cnt));
        chk("ras_ovf", idx, 32'(ras_ovf), 32'(e.ovf));
        chk("ras_unf", idx, 32'(ras_unf), 32'(e.unf));
    endtask

    task automatic drive(input vec_t v);
        {trap, stall, ret, call, jump, branch, zero} = v.ctl;
        br_offset  = v.off;
        jmp_target = v.tgt;
        trap_vec   = v.tvec;
    endtask

    initial begin
        vec_t idle;
        idle = mk(NON, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(idle);

        // ctl, br_offset, jmp_target, trap_vec -> pc, epc, count, ovf, unf
        tbl.push_back(mk(NON,      32'h0,        32'h0,        32'h0,  32'h101,      32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(JMP,      32'h0,        32'h10,       32'h0,  32'h10,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(BR|ZR,    32'hFFFFFFFC, 32'h0,        32'h0,  32'h0C,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(JMP,      32'h0,        32'h10,       32'h0,  32'h10,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(BR,       32'hFFFFFFFC, 32'h0,        32'h0,  32'h11,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(JMP,      32'h0,        32'h20,       32'h0,  32'h20,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(STL|JMP,  32'h0,        32'h99,       32'h0,  32'h20,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(STL|TRP,  32'h0,        32'h0,        32'h80, 32'h80,       32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(JMP,      32'h0,        32'h10,       32'h0,  32'h10,       32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h30,       32'h0,  32'h30,       32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h50,       32'h0,  32'h50,       32'h20, 3'd2, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h70,       32'h0,  32'h70,       32'h20, 3'd3, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h51,       32'h20, 3'd2, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h31,       32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h11,       32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h200,      32'h0,  32'h200,      32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h300,      32'h0,  32'h300,      32'h20, 3'd2, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h400,      32'h0,  32'h400,      32'h20, 3'd3, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h500,      32'h0,  32'h500,      32'h20, 3'd4, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h600,      32'h0,  32'h600,      32'h20, 3'd4, 1, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h501,      32'h20, 3'd3, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h401,      32'h20, 3'd2, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h301,      32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h201,      32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h202,      32'h20, 3'd0, 0, 1));
        tbl.push_back(mk(NON,      32'h0,        32'h0,        32'h0,  32'h203,      32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(CAL,      32'h0,        32'h700,      32'h0,  32'h700,      32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(CAL|RET,  32'h0,        32'h800,      32'h0,  32'h800,      32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(RET,      32'h0,        32'h0,        32'h0,  32'h701,      32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(CAL|RET,  32'h0,        32'h900,      32'h0,  32'h900,      32'h20, 3'd1, 0, 0));
        tbl.push_back(mk(RET|JMP,  32'h0,        32'h111,      32'h0,  32'h702,      32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(JMP,      32'h0,        32'hFFFFFFFF, 32'h0,  32'hFFFFFFFF, 32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(NON,      32'h0,        32'h0,        32'h0,  32'h0,        32'h20, 3'd0, 0, 0));
        tbl.push_back(mk(TRP|CAL,  32'h0,        32'h123,      32'h40, 32'h40,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(STL|RET,  32'h0,        32'h0,        32'h0,  32'h40,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(STL|CAL,  32'h0,        32'h555,      32'h0,  32'h40,       32'h0,  3'd0, 0, 0));
        tbl.push_back(mk(BR|ZR,    32'h10,       32'h0,        32'h0,  32'h50,       32'h0,  3'd0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, mk(NON, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0));
        reset = 1'b1;

        foreach (tbl[i]) begin
            vec_t e;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_all(i, e);
        end

        // Asynchronous reset mid-cycle while a call is being requested.
        drive(mk(CAL, 32'h0, 32'hABC, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0));
        #3;
        reset = 1'b0;
        #1;
        check_all(100, mk(NON, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_all(101, mk(NON, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0));
        drive(idle);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all(102, mk(NON, 32'h0, 32'h0, 32'h0, 32'h101, 32'h0, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_all(103, mk(NON, 32'h0, 32'h0, 32'h0, 32'h102, 32'h0, 3'd0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
